// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: bus widths and the
// response owner tag encoding.
package sram_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WEN_W  = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_MEM  = 2'b10
  } owner_t;

endpackage

// File: rtl/sram_rsp_router.sv
// Response router: remembers who owns the read issued last cycle, pulses
// that requester's rvalid, and holds the last read data per requester.
module sram_rsp_router
  import sram_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  owner_t            issue_tag,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata
);

  owner_t            tag_q;
  logic [DATA_W-1:0] if_hold_q;
  logic [DATA_W-1:0] mem_hold_q;

  // Owner of the read issued this cycle; writes and idle cycles load NONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= OWN_NONE;
    else     tag_q <= issue_tag;
  end

  // Capture response data into the owner's hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_hold_q  <= '0;
      mem_hold_q <= '0;
    end else begin
      if (tag_q == OWN_IF)  if_hold_q  <= sram_rdata;
      if (tag_q == OWN_MEM) mem_hold_q <= sram_rdata;
    end
  end

  // The response cycle bypasses the hold register so data is visible with rvalid
  always_comb begin
    if_rvalid  = (tag_q == OWN_IF);
    mem_rvalid = (tag_q == OWN_MEM);
    if_rdata   = if_rvalid  ? sram_rdata : if_hold_q;
    mem_rdata  = mem_rvalid ? sram_rdata : mem_hold_q;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the shared single-port SRAM between instruction fetch and data
// access. Data wins by default; define SRAM_ARB_FAIR_EN to force a waiting
// fetch through after MAX_STREAK consecutive data grants.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic [WEN_W-1:0]  mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              sram_en,
  output logic [WEN_W-1:0]  sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              stallreq_for_arb
);

  if ((MAX_STREAK < 1) || (MAX_STREAK > 15)) begin : g_bad_streak
    $error("sram_port_arbiter: MAX_STREAK out of range 1..15");
  end

  logic   if_force;
  owner_t issue_tag;

`ifdef SRAM_ARB_FAIR_EN
  logic [3:0] streak_q;

  // Count data grants won against a waiting fetch; any fetch grant or idle fetch clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       streak_q <= '0;
    else if (!if_req || if_gnt)    streak_q <= '0;
    else if (mem_gnt && (streak_q != 4'(MAX_STREAK)))
                                   streak_q <= streak_q + 4'd1;
  end

  assign if_force = if_req && (streak_q == 4'(MAX_STREAK));
`else
  assign if_force = 1'b0;
`endif

  // Grant selection and SRAM port mux
  always_comb begin
    mem_gnt    = mem_req && !if_force;
    if_gnt     = if_req && !mem_gnt;
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    issue_tag  = OWN_NONE;
    if (mem_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = mem_wen;
      sram_addr  = mem_addr;
      sram_wdata = mem_wdata;
      if (mem_wen == '0) issue_tag = OWN_MEM;
    end else if (if_gnt) begin
      sram_en   = 1'b1;
      sram_addr = if_addr;
      issue_tag = OWN_IF;
    end
    stallreq_for_arb = (if_req && !if_gnt) || (mem_req && !mem_gnt);
  end

  sram_rsp_router u_rsp_router (
    .clk        (clk),
    .rst        (rst),
    .issue_tag  (issue_tag),
    .sram_rdata (sram_rdata),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM.
// Build with +define+SRAM_ARB_FAIR_EN to exercise the fairness variant.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stallreq_for_arb;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] mem_array [0:255];
  logic        if_pend, mem_pend;

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_STREAK(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_gnt           (if_gnt),
    .if_rvalid        (if_rvalid),
    .if_rdata         (if_rdata),
    .mem_req          (mem_req),
    .mem_wen          (mem_wen),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .sram_en          (sram_en),
    .sram_wen         (sram_wen),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .sram_rdata       (sram_rdata),
    .stallreq_for_arb (stallreq_for_arb)
  );

  // Behavioural SRAM: read data appears the cycle after the access
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'b0000) sram_rdata <= mem_array[sram_addr[9:2]];
      else begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) mem_array[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // A request left waiting at a clock edge must still be present afterwards
  always @(posedge clk) begin
    if_pend  <= if_req  && !if_gnt  && !rst;
    mem_pend <= mem_req && !mem_gnt && !rst;
  end
  always @(negedge clk) begin
    if (if_pend)  check("if_req_held",  {31'd0, if_req},  32'd1);
    if (mem_pend) check("mem_req_held", {31'd0, mem_req}, 32'd1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_wen = '0; mem_addr = '0; mem_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_array[i] = 32'h0;
    mem_array[8'h10] = 32'h2402_0001;          // 0x040
    mem_array[8'h11] = 32'h1111_0044;          // 0x044
    mem_array[8'h80] = 32'h2222_0200;          // 0x200
    for (int k = 0; k < 6; k++) mem_array[8'hC0 + k] = 32'hA000_0000 + k;  // 0x300..
    sram_rdata = '0;
    rst = 1'b1;
    idle();

    // Reset state
    next_cycle(); next_cycle();
    check("rst_if_rvalid",  {31'd0, if_rvalid},  32'd0);
    check("rst_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    check("rst_if_rdata",   if_rdata,  32'h0);
    check("rst_mem_rdata",  mem_rdata, 32'h0);
    check("rst_sram_en",    {31'd0, sram_en}, 32'd0);
    check("rst_sram_wen",   {28'd0, sram_wen}, 32'd0);
    check("rst_stall",      {31'd0, stallreq_for_arb}, 32'd0);
    rst = 1'b0;

    // Single fetch
    next_cycle();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1;
    check("f1_if_gnt",    {31'd0, if_gnt},  32'd1);
    check("f1_sram_en",   {31'd0, sram_en}, 32'd1);
    check("f1_sram_addr", sram_addr, 32'h40);
    check("f1_sram_wen",  {28'd0, sram_wen}, 32'd0);
    check("f1_stall",     {31'd0, stallreq_for_arb}, 32'd0);
    next_cycle();
    idle();
    #1;
    check("f1_if_rvalid",  {31'd0, if_rvalid},  32'd1);
    check("f1_if_rdata",   if_rdata, 32'h2402_0001);
    check("f1_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    next_cycle();
    check("f1_if_rvalid_off", {31'd0, if_rvalid}, 32'd0);
    check("f1_if_rdata_hold", if_rdata, 32'h2402_0001);

    // Data write, then read back
    mem_req = 1'b1; mem_wen = 4'b1111; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    #1;
    check("w_mem_gnt",    {31'd0, mem_gnt},  32'd1);
    check("w_sram_wen",   {28'd0, sram_wen}, 32'hF);
    check("w_sram_addr",  sram_addr,  32'h100);
    check("w_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    next_cycle();
    mem_wen = 4'b0000; mem_wdata = '0;
    #1;
    check("w_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    check("w_if_rvalid",  {31'd0, if_rvalid},  32'd0);
    check("rb_sram_wdata", sram_wdata, 32'h0);
    next_cycle();
    idle();
    #1;
    check("rb_mem_rvalid", {31'd0, mem_rvalid}, 32'd1);
    check("rb_mem_rdata",  mem_rdata, 32'hDEAD_BEEF);

    // Collision: data first, fetch stalled one cycle
    next_cycle();
    if_req = 1'b1; if_addr = 32'h44;
    mem_req = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h200;
    #1;
    check("c0_mem_gnt",   {31'd0, mem_gnt}, 32'd1);
    check("c0_if_gnt",    {31'd0, if_gnt},  32'd0);
    check("c0_stall",     {31'd0, stallreq_for_arb}, 32'd1);
    check("c0_sram_addr", sram_addr, 32'h200);
    next_cycle();
    mem_req = 1'b0;
    #1;
    check("c1_mem_rvalid", {31'd0, mem_rvalid}, 32'd1);
    check("c1_mem_rdata",  mem_rdata, 32'h2222_0200);
    check("c1_if_gnt",     {31'd0, if_gnt}, 32'd1);
    check("c1_stall",      {31'd0, stallreq_for_arb}, 32'd0);
    check("c1_sram_addr",  sram_addr, 32'h44);
    next_cycle();
    idle();
    #1;
    check("c2_if_rvalid",  {31'd0, if_rvalid},  32'd1);
    check("c2_if_rdata",   if_rdata, 32'h1111_0044);
    check("c2_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    check("c2_mem_rdata",  mem_rdata, 32'h2222_0200);

    // Back-to-back reads alternating fetch/data
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      idle();
      if (k < 6) begin
        if (k % 2 == 0) begin if_req = 1'b1; if_addr = 32'h300 + 32'(4 * k); end
        else begin mem_req = 1'b1; mem_addr = 32'h300 + 32'(4 * k); end
      end
      #1;
      if (k > 0) begin
        check("b2b_if_rvalid",  {31'd0, if_rvalid},  {31'd0, ((k - 1) % 2 == 0)});
        check("b2b_mem_rvalid", {31'd0, mem_rvalid}, {31'd0, ((k - 1) % 2 == 1)});
        if ((k - 1) % 2 == 0) check("b2b_if_rdata",  if_rdata,  32'hA000_0000 + 32'(k - 1));
        else                  check("b2b_mem_rdata", mem_rdata, 32'hA000_0000 + 32'(k - 1));
      end
      if (k < 6) check("b2b_sram_en", {31'd0, sram_en}, 32'd1);
    end

    // Fairness: both held; fetch forced through on the 5th cycle only when enabled
    next_cycle();
    if_req = 1'b1; if_addr = 32'h40;
    mem_req = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h100;
    for (int c = 1; c <= 5; c++) begin
      logic exp_if;
`ifdef SRAM_ARB_FAIR_EN
      exp_if = (c == 5);
`else
      exp_if = 1'b0;
`endif
      #1;
      check("fair_if_gnt",  {31'd0, if_gnt},  {31'd0, exp_if});
      check("fair_mem_gnt", {31'd0, mem_gnt}, {31'd0, !exp_if});
      check("fair_stall",   {31'd0, stallreq_for_arb}, {31'd0, !exp_if});
      if (c < 5) next_cycle();
    end
    next_cycle();
`ifdef SRAM_ARB_FAIR_EN
    idle();
`else
    mem_req = 1'b0;
    #1;
    check("fair_if_gnt_late", {31'd0, if_gnt}, 32'd1);
    next_cycle();
    idle();
`endif

    // Reset the cycle after a fetch grant: response suppressed
    next_cycle();
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    check("r_if_gnt", {31'd0, if_gnt}, 32'd1);
    next_cycle();
    idle();
    rst = 1'b1;
    #1;
    check("r_if_rvalid",  {31'd0, if_rvalid},  32'd0);
    check("r_if_rdata",   if_rdata,  32'h0);
    check("r_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    check("r_mem_rdata",  mem_rdata, 32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check("r_if_rvalid_after", {31'd0, if_rvalid}, 32'd0);
    check("r_sram_en_after",   {31'd0, sram_en},   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
